// File: rtl/debug_dump_uart_tx.sv
// debug_dump_uart_tx: sweeps the debug register port and streams header, PC and registers as UART 8N1 bytes
module debug_dump_uart_tx #(
    parameter int         WIDTH        = 32,
    parameter int         NUM_REGS     = 16,
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] fetch_pc,
    input  logic [WIDTH-1:0] debug_reg_out,
    output logic [3:0]       debug_reg_select,
    output logic             tx,
    output logic             busy,
    output logic             done
);
    localparam int NB = WIDTH / 8;
    localparam int BW = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, SEND_HDR, SEND_PC, SELECT, SEND_REG, FINISH} state_t;
    state_t           r_state, w_state;
    logic [BW-1:0]    r_baud, w_baud;
    logic [3:0]       r_bit, w_bit, r_sel, w_sel;
    logic [7:0]       r_idx, w_idx;
    logic [WIDTH-1:0] r_word, w_word;
    logic             r_tx, r_busy, r_done;
    logic             w_bit_end, w_byte_end, w_word_end, w_send, w_tx;
    logic [9:0]       w_frame;
    always_comb begin
        w_state = r_state;
        w_baud = r_baud;
        w_bit = r_bit;
        w_idx = r_idx;
        w_word = r_word;
        w_sel = r_sel;
        w_bit_end = r_baud == BW'(CLKS_PER_BIT - 1);
        w_byte_end = w_bit_end && r_bit == 4'd9;
        w_word_end = w_byte_end && r_idx == 8'(NB - 1);
        if (r_state inside {SEND_HDR, SEND_PC, SEND_REG}) begin
            w_baud = w_bit_end ? '0 : r_baud + 1'b1;
            w_bit = w_byte_end ? '0 : r_bit + 4'(w_bit_end);
        end
        case (r_state)
            IDLE: if (start) begin
                w_state = SEND_HDR;
                w_word = fetch_pc;
            end
            SEND_HDR: w_state = w_byte_end ? SEND_PC : SEND_HDR;
            SEND_PC, SEND_REG: if (w_byte_end) begin
                w_idx = w_word_end ? '0 : r_idx + 1'b1;
                w_word = r_word << 8;
                if (w_word_end && r_state == SEND_PC) w_state = SELECT;
                else if (w_word_end) begin
                    w_state = r_sel == 4'(NUM_REGS - 1) ? FINISH : SELECT;
                    w_sel = r_sel == 4'(NUM_REGS - 1) ? 4'd0 : r_sel + 1'b1;
                end
            end
            // leaving SELECT is the capture edge: debug_reg_out has settled for the new select
            SELECT: begin
                w_state = SEND_REG;
                w_word = debug_reg_out;
            end
            default: w_state = IDLE;
        endcase
        w_send = w_state inside {SEND_HDR, SEND_PC, SEND_REG};
        w_frame = {1'b1, w_state == SEND_HDR ? HEADER : w_word[WIDTH-1 -: 8], 1'b0};
        w_tx = w_send ? w_frame[w_bit] : 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_baud <= '0;
            r_bit <= '0;
            r_idx <= '0;
            r_word <= '0;
            r_sel <= '0;
            r_tx <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_state <= w_state;
            r_baud <= w_baud;
            r_bit <= w_bit;
            r_idx <= w_idx;
            r_word <= w_word;
            r_sel <= w_sel;
            r_tx <= w_tx;
            r_busy <= w_send || w_state == SELECT;
            r_done <= w_state == FINISH;
        end
    end
    assign debug_reg_select = r_sel;
    assign tx = r_tx;
    assign busy = r_busy;
    assign done = r_done;
endmodule

// File: tb/tb_debug_dump_uart_tx.sv
// tb_debug_dump_uart_tx: frames checked every cycle against a frame-position reference plus a UART decoder
module tb_debug_dump_uart_tx;
    localparam int WIDTH = 32, NUM_REGS = 16, CPB = 4, NB = WIDTH / 8;
    localparam logic [7:0] HEADER = 8'hA5;
    localparam int L = 10 * CPB, P = L * (1 + NB), S = 1 + L * NB, DONE_K = P + NUM_REGS * S;
    localparam int NBYTES = 1 + NB * (NUM_REGS + 1);
    logic clk = 0, reset = 1, start = 0;
    logic [WIDTH-1:0] fetch_pc = '0, debug_reg_out;
    logic [3:0] debug_reg_select;
    logic tx, busy, done;
    logic [WIDTH-1:0] regs [NUM_REGS], snap [NUM_REGS], m_cap [NUM_REGS], m_pc;
    bit m_on = 0;
    int m_k = 0, cyc = 0, cmp_n = 0, err_n = 0;
    logic [7:0] dec_q [$];
    logic [9:0] dsh = '0;
    int dc = 0;
    bit dact = 0;

    always #5 clk = ~clk;
    assign debug_reg_out = regs[debug_reg_select];

    debug_dump_uart_tx #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .CLKS_PER_BIT(CPB), .HEADER(HEADER)) dut (
        .clk(clk), .reset(reset), .start(start), .fetch_pc(fetch_pc), .debug_reg_out(debug_reg_out),
        .debug_reg_select(debug_reg_select), .tx(tx), .busy(busy), .done(done)
    );

    // independent UART receiver sampling mid-bit
    always @(negedge clk) begin
        if (!dact && tx === 1'b0) begin
            dact = 1;
            dc = 0;
        end
        if (dact) begin
            if (dc % CPB == CPB / 2) dsh = {tx, dsh[9:1]};
            dc++;
            if (dc == 10 * CPB) begin
                dact = 0;
                dec_q.push_back(dsh[8:1]);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] word_byte(input logic [WIDTH-1:0] w, input int i);
        return 8'(w >> (8 * (NB - 1 - i)));
    endfunction

    function automatic logic line_bit(input logic [7:0] b, input int p);
        logic [7:0] t;
        t = b >> (p - 1);
        return p == 0 ? 1'b0 : (p == 9 ? 1'b1 : t[0]);
    endfunction

    function automatic logic [7:0] frame_byte(input int b, input logic [WIDTH-1:0] pc);
        if (b == 0) return HEADER;
        if (b <= NB) return word_byte(pc, b - 1);
        return word_byte(snap[(b - 1 - NB) / NB], (b - 1 - NB) % NB);
    endfunction

    task automatic tick();
        int r, o;
        logic e_tx, e_busy, e_done;
        logic [3:0] e_sel;
        @(posedge clk);
        if (reset) m_on = 0;
        else if (m_on) begin
            if (m_k >= P && m_k < DONE_K && (m_k - P) % S == 0) m_cap[(m_k - P) / S] = regs[(m_k - P) / S];
            m_k++;
            if (m_k > DONE_K) m_on = 0;
        end else if (start) begin
            m_on = 1;
            m_k = 0;
            m_pc = fetch_pc;
        end
        @(negedge clk);
        cyc++;
        e_tx = 1;
        e_busy = m_on;
        e_done = 0;
        e_sel = 0;
        if (m_on && m_k == DONE_K) begin
            e_busy = 0;
            e_done = 1;
        end else if (m_on && m_k < P)
            e_tx = line_bit(m_k / L == 0 ? HEADER : word_byte(m_pc, m_k / L - 1), (m_k % L) / CPB);
        else if (m_on) begin
            r = (m_k - P) / S;
            o = (m_k - P) % S;
            e_sel = 4'(r);
            if (o > 0) e_tx = line_bit(word_byte(m_cap[r], (o - 1) / L), ((o - 1) % L) / CPB);
        end
        chk("tx", tx, e_tx);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("sel", debug_reg_select, e_sel);
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int i = 0; i < 2 * DONE_K && at < 0; i++) begin
            tick();
            if (done === 1'b1) at = cyc;
        end
        chk("done_seen", at >= 0, 1);
    endtask

    task automatic check_frame(input int base, input logic [WIDTH-1:0] pc);
        int n;
        n = dec_q.size() - base;
        chk("byte_count", n, NBYTES);
        for (int b = 0; b < NBYTES && b < n; b++) chk("frame_byte", dec_q[base + b], frame_byte(b, pc));
    endtask

    task automatic pulse_start(output int c0);
        start = 1;
        tick();
        start = 0;
        c0 = cyc;
    endtask

    initial begin
        int c0, at, nd, base;
        logic [WIDTH-1:0] pco, w;
        for (int n = 0; n < NUM_REGS; n++) regs[n] = 32'h1111_1111 * n;
        repeat (3) tick();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sel", debug_reg_select, 0);
        reset = 0;
        repeat (2) tick();

        fetch_pc = 32'h0000_0010;
        snap = regs;
        base = dec_q.size();
        pulse_start(c0);
        chk("hdr_start_bit", tx, 0);
        chk("busy_first", busy, 1);
        wait_done(at);
        chk("done_latency", at - c0, 2776);
        chk("sel_at_done", debug_reg_select, 0);
        chk("busy_at_done", busy, 0);
        repeat (2) tick();
        check_frame(base, 32'h10);
        chk("lit_b0", dec_q[base], 8'hA5);
        chk("lit_b4", dec_q[base + 4], 8'h10);
        chk("lit_b8", dec_q[base + 8], 8'h00);
        chk("lit_b9", dec_q[base + 9], 8'h11);
        chk("lit_b68", dec_q[base + 68], 8'hFF);

        for (int n = 0; n < NUM_REGS; n++) regs[n] = $urandom;
        fetch_pc = $urandom;
        pco = fetch_pc;
        snap = regs;
        base = dec_q.size();
        pulse_start(c0);
        fetch_pc = $urandom;
        for (int i = 0; i < 2 * DONE_K && debug_reg_select != 4'd3; i++) tick();
        tick();
        for (int j = 0; j < 5; j++) begin
            repeat ($urandom_range(1, 25)) tick();
            regs[3] = $urandom;
        end
        wait_done(at);
        repeat (2) tick();
        check_frame(base, pco);
        w = {dec_q[base + 5 + 4 * 3], dec_q[base + 6 + 4 * 3], dec_q[base + 7 + 4 * 3], dec_q[base + 8 + 4 * 3]};
        chk("r3_orig", w, snap[3]);
        w = {dec_q[base + 1], dec_q[base + 2], dec_q[base + 3], dec_q[base + 4]};
        chk("pc_orig", w, pco);

        snap = regs;
        fetch_pc = $urandom;
        pco = fetch_pc;
        base = dec_q.size();
        pulse_start(c0);
        repeat (10 * L) tick();
        start = 1;
        tick();
        start = 0;
        wait_done(at);
        nd = 0;
        repeat (300) begin
            tick();
            nd += int'(done === 1'b1);
        end
        chk("extra_done", nd, 0);
        check_frame(base, pco);

        snap = regs;
        pco = fetch_pc;
        base = dec_q.size();
        start = 1;
        tick();
        c0 = cyc;
        wait_done(at);
        chk("hold_latency", at - c0, 2776);
        check_frame(base, pco);
        tick();
        chk("idle_tx", tx, 1);
        chk("idle_busy", busy, 0);
        tick();
        chk("restart_tx", tx, 0);
        chk("restart_busy", busy, 1);
        start = 0;
        c0 = cyc;
        wait_done(at);
        chk("second_latency", at - c0, 2776);

        for (int n = 0; n < NUM_REGS; n++) regs[n] = $urandom;
        fetch_pc = $urandom;
        pulse_start(c0);
        repeat (99) tick();
        reset = 1;
        tick();
        reset = 0;
        chk("rstmid_tx", tx, 1);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_sel", debug_reg_select, 0);
        nd = 0;
        repeat (100) begin
            tick();
            nd += int'(done === 1'b1);
        end
        chk("rstmid_no_done", nd, 0);
        snap = regs;
        pco = fetch_pc;
        base = dec_q.size();
        pulse_start(c0);
        wait_done(at);
        chk("post_rst_latency", at - c0, 2776);
        repeat (2) tick();
        check_frame(base, pco);

        repeat (2) begin
            for (int n = 0; n < NUM_REGS; n++) regs[n] = $urandom;
            fetch_pc = $urandom;
            pulse_start(c0);
            at = -1;
            for (int i = 0; i < 2 * DONE_K && at < 0; i++) begin
                tick();
                if (done === 1'b1) at = cyc;
                if ($urandom_range(0, 49) == 0) regs[$urandom_range(0, NUM_REGS - 1)] = $urandom;
                if ($urandom_range(0, 29) == 0) fetch_pc = $urandom;
            end
            chk("rand_latency", at - c0, 2776);
            repeat ($urandom_range(1, 20)) tick();
        end

        start = 1;
        reset = 1;
        tick();
        start = 0;
        reset = 0;
        chk("rst_start_tx", tx, 1);
        chk("rst_start_busy", busy, 0);
        repeat (10) tick();
        chk("rst_start_idle_tx", tx, 1);
        chk("rst_start_idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
